// File: rtl/reg_file_32x64_pkg.sv
// Shared types and constants for the 32x64 architectural register file,
// plus the bit-major 32:1 read mux used by each read port.
package reg_file_32x64_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;
  // Bit-major storage view: bm[bit][entry], so each output bit is a 32:1 select.
  typedef logic [DATA_W-1:0][NUM_REGS-1:0] word_bm_t;

  localparam reg_addr_t XZR_IDX = 5'd31;

  function automatic word_t read_mux(input word_bm_t bm, input reg_addr_t addr);
    word_t w;
    w = '0;
    for (int b = 0; b < DATA_W; b++) begin
      w[b] = bm[b][addr];
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_file_32x64_decoder.sv
// wr_en-gated one-hot write select; the XZR slot has no select line since
// that entry holds no state.
module reg_file_32x64_decoder
  import reg_file_32x64_pkg::*;
(
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  output logic [NUM_REGS-2:0]   wr_sel
);

  // One-hot decode of the write address for the 31 live entries.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (wr_en && (wr_addr == REG_ADDR_W'(i))) begin
        wr_sel[i] = 1'b1;
      end else begin
        wr_sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file_32x64.sv
// 32 x 64-bit register file, one write port and two combinational read ports,
// with XZR at index 31 and optional same-cycle write-to-read forwarding.
module reg_file_32x64
  import reg_file_32x64_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_a,
  input  logic [REG_ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_a,
  output logic [DATA_W-1:0]     rd_data_b
);

  logic [NUM_REGS-2:0]             wr_sel;
  logic [NUM_REGS-2:0][DATA_W-1:0] regs_d;
  logic [NUM_REGS-2:0][DATA_W-1:0] regs_q;
  word_bm_t                        mem_bm;
  word_t                           mux_a;
  word_t                           mux_b;
  logic                            fwd_a;
  logic                            fwd_b;

  reg_file_32x64_decoder u_decoder (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_sel  (wr_sel)
  );

  // Next-state of the live entries: only the selected entry takes wr_data.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NUM_REGS - 1; r++) begin
      if (wr_sel[r]) begin
        regs_d[r] = wr_data;
      end else begin
        regs_d[r] = regs_q[r];
      end
    end
  end

  // Storage flops with asynchronous clear; a write on a reset edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Re-pack as bit-major; the XZR column keeps its zero default.
  always_comb begin
    mem_bm = '0;
    for (int r = 0; r < NUM_REGS - 1; r++) begin
      for (int b = 0; b < DATA_W; b++) begin
        mem_bm[b][r] = regs_q[r][b];
      end
    end
  end

  assign mux_a = read_mux(mem_bm, rd_addr_a);
  assign mux_b = read_mux(mem_bm, rd_addr_b);

  // Forwarding is held off during reset so the outputs stay zero then.
  always_comb begin
    fwd_a = BYPASS && reset_n && wr_en && (wr_addr != XZR_IDX) && (wr_addr == rd_addr_a);
    fwd_b = BYPASS && reset_n && wr_en && (wr_addr != XZR_IDX) && (wr_addr == rd_addr_b);
    if (fwd_a) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = mux_a;
    end
    if (fwd_b) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = mux_b;
    end
  end

endmodule
